fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
- Write-side front end of the asynchronous FIFO; runs entirely in the write clock domain.
- Accepts a valid/ready stream with a packet-last marker from the producer and absorbs it in a 2-entry skid buffer.
- Drives the FIFO write strobe and write data, honouring the FIFO's active-low full flag.
- Also provides a flush/drain sequence, word and packet counters, and a stall watchdog.

Parameters:
- DATA_WIDTH, 18, width of the stream data and FIFO write data; must be even.
- CNT_WIDTH, 16, width of the word and packet counters.
- STALL_LIMIT, 1024, consecutive stalled cycles that set stall_err_o; must be >= 1 and < 2^CNT_WIDTH.

Ports:
- clk_wr_i  in  1  write clock; the FIFO write clock.
- reset  in  1  asynchronous, active-low reset.
- s_valid_i  in  1  producer word valid.
- s_ready_o  out  1  block can accept a word.
- s_data_i  in  DATA_WIDTH  producer data.
- s_last_i  in  1  word is the last of its packet.
- flush_i  in  1  request: stop accepting and drain the buffer into the FIFO.
- fifo_full_n_i  in  1  FIFO full flag, active-low (0 = full).
- wr_o  out  1  FIFO write strobe, to wr_i.
- data_o  out  DATA_WIDTH  FIFO write data, to data_in_i.
- busy_o  out  1  buffer non-empty or flush in progress.
- flush_done_o  out  1  one-cycle pulse when a flush completes.
- word_cnt_o  out  CNT_WIDTH  words written to the FIFO.
- pkt_cnt_o  out  CNT_WIDTH  last-marked words written to the FIFO.
- stall_err_o  out  1  sticky watchdog error.

Behaviour:
- Reset (reset=0, async)
  - Buffer empty, pointers 0, FSM in IDLE.
  - s_ready_o=1, wr_o=0, data_o=0, busy_o=0, flush_done_o=0, counters=0, stall_err_o=0.
- Buffer
  - 2 entries of {last, data}, with head pointer, tail pointer and a 2-bit count (0..2).
  - Accept = s_valid_i & s_ready_o: writes the tail entry at the posedge.
  - Write = wr_o: pops the head entry at the posedge.
  - Accept and write in the same cycle: count is unchanged. This gives 1 word/cycle throughput.
- s_ready_o
  - High when count<2 and state != FLUSH.
  - Decoded from registers only; no combinational path from s_valid_i or flush_i.
- wr_o
  - Equals (count!=0) & fifo_full_n_i.
  - data_o always presents the head data (0 when empty is not required; a don't-care when wr_o=0).
- Latency: a word accepted at edge N can be written at edge N+1 at the earliest (wr_o is high during cycle N+1).
- Full handling: while fifo_full_n_i=0, wr_o=0 and data is held. Once count=2, s_ready_o drops.
- FSM states: IDLE, PKT, FLUSH.
  - IDLE -> PKT: on accept with s_last_i=0.
  - PKT -> IDLE: on accept with s_last_i=1.
  - IDLE/PKT -> FLUSH: when flush_i=1. A word accepted in the same cycle as flush_i is kept and drained.
  - FLUSH -> IDLE: when count reaches 0 (including at the same edge as the final write); flush_done_o pulses for that one cycle.
  - flush_i held high after completion re-enters FLUSH, which exits immediately with another done pulse one cycle later.
  - A single-word packet (s_last_i=1 in IDLE) stays in IDLE.
- Counters
  - word_cnt_o increments on every wr_o.
  - pkt_cnt_o increments on wr_o when the head last bit is 1.
  - Both saturate at 2^CNT_WIDTH-1.
- Watchdog
  - stall counter increments each cycle count!=0 and fifo_full_n_i=0; it is cleared on any cycle that condition is false.
  - When it reaches STALL_LIMIT, stall_err_o is set and stays 1 until reset.
- busy_o = (count!=0) | (state==FLUSH).
- Reset mid-operation: buffered words are discarded and nothing is written.

Decomposition:
- Package fifo_wr_pkg:
  - typedef enum logic [1:0] {IDLE, PKT, FLUSH} wr_state_e.
  - typedef of the buffer entry struct {last, data}, parameterised by DATA_WIDTH via the module.
- One natural sub-module, fifo_wr_skid: the 2-entry buffer with count, head and tail. The FSM, counters and watchdog stay in the top module.

Test Plan:
- Reset then 4-word packet (last on word 4), fifo_full_n_i=1 throughout -> wr_o high 4 consecutive cycles, each starting one cycle after its accept; data in order; word_cnt_o=4, pkt_cnt_o=1, s_ready_o stays 1.
- fifo_full_n_i=0 for 10 cycles while streaming -> 2 words accepted then s_ready_o=0, wr_o=0. After release, both buffered words are written first in order, then streaming resumes with no loss.
- STALL_LIMIT=8, full held 8 cycles with 1 buffered word -> stall_err_o=1 after the 8th stalled cycle; it stays 1 after full releases until reset.
- flush_i pulsed with 2 words buffered and full=0 for 3 cycles -> s_ready_o=0 from the next cycle; after release, 2 writes; flush_done_o pulses on the cycle of the final write; FSM returns to IDLE.
- Counter saturation with CNT_WIDTH=4 -> 20 single-word packets give word_cnt_o=15 and pkt_cnt_o=15.
- reset asserted with 2 words buffered and state PKT -> all outputs return to reset values immediately, and no wr_o follows reset release.

Source files
------------

// File: rtl/fifo_wr_pkg.sv
// Shared types and constants for the asynchronous FIFO write-side front end.
package fifo_wr_pkg;

  // Write-side sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    FLUSH = 2'd2
  } wr_state_e;

  // Skid buffer geometry: two entries, so a 2-bit occupancy count (0..2).
  localparam int unsigned SKID_DEPTH = 2;
  localparam logic [1:0]  SKID_EMPTY = 2'd0;
  localparam logic [1:0]  SKID_ONE   = 2'd1;
  localparam logic [1:0]  SKID_FULL  = 2'd2;

endpackage

// File: rtl/fifo_wr_skid.sv
// Two-entry skid buffer holding {last, data}. A push and a pop may occur in
// the same cycle, which keeps the occupancy constant and sustains one word
// per cycle. The caller guarantees push only when not full, pop only when
// not empty.
module fifo_wr_skid
  import fifo_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk_wr_i,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  push_last,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  head_last,
  output logic [DATA_WIDTH-1:0] head_data
);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t mem [SKID_DEPTH];
  logic   head_ptr;
  logic   tail_ptr;
  entry_t head;

  // Storage: the tail entry is written on every push.
  always_ff @(posedge clk_wr_i or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[tail_ptr] <= '{last: push_last, data: push_data};
    end
  end

  // Pointers toggle on their own operation; count tracks push minus pop.
  always_ff @(posedge clk_wr_i or negedge reset) begin
    if (!reset) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= SKID_EMPTY;
    end else begin
      head_ptr <= head_ptr ^ pop;
      tail_ptr <= tail_ptr ^ push;
      case ({push, pop})
        2'b10:   count <= count + SKID_ONE;
        2'b01:   count <= count - SKID_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[head_ptr];
  assign head_last = head.last;
  assign head_data = head.data;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side front end of the asynchronous FIFO. Absorbs a valid/ready stream
// in a 2-entry skid buffer and writes it into the FIFO whenever the FIFO is
// not full. Also sequences flush/drain, counts words and packets, and raises
// a sticky error if the buffer stays stalled behind a full FIFO too long.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | between packets; accepting words
//   PKT   | inside a packet (a non-last word has been accepted)
//   FLUSH | input closed; draining buffered words into the FIFO
module fifo_wr_ctrl
  import fifo_wr_pkg::*;
#(
  parameter int DATA_WIDTH  = 18,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                  clk_wr_i,
  input  logic                  reset,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  input  logic                  flush_i,
  input  logic                  fifo_full_n_i,
  output logic                  wr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  flush_done_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
  output logic                  stall_err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] STALL_LOAD = CNT_WIDTH'(STALL_LIMIT);

  wr_state_e              state;
  logic [1:0]             count;
  logic                   head_last;
  logic [DATA_WIDTH-1:0]  head_data;
  logic                   accept;
  logic                   stalled;
  logic [CNT_WIDTH-1:0]   stall_tmr;

  fifo_wr_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_wr_i  (clk_wr_i),
    .reset     (reset),
    .push      (accept),
    .push_last (s_last_i),
    .push_data (s_data_i),
    .pop       (wr_o),
    .count     (count),
    .head_last (head_last),
    .head_data (head_data)
  );

  // Ready depends on registered state only, so there is no path from
  // s_valid_i or flush_i back to s_ready_o.
  assign s_ready_o = (count != SKID_FULL) && (state != FLUSH);
  assign accept    = s_valid_i & s_ready_o;
  assign wr_o      = (count != SKID_EMPTY) & fifo_full_n_i;
  assign data_o    = head_data;
  assign busy_o    = (count != SKID_EMPTY) | (state == FLUSH);
  assign stalled   = (count != SKID_EMPTY) & ~fifo_full_n_i;

  // Done marks the cycle in which the buffer becomes empty while flushing:
  // either already empty, or the last word is being written right now.
  // No word can be accepted during FLUSH, so only the pop matters here.
  assign flush_done_o = (state == FLUSH) &&
                        ((count == SKID_EMPTY) || ((count == SKID_ONE) && wr_o));

  // Packet/flush sequencing; flush takes priority over packet tracking.
  always_ff @(posedge clk_wr_i or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (flush_i)                  state <= FLUSH;
          else if (accept && !s_last_i) state <= PKT;
        end
        PKT: begin
          if (flush_i)                  state <= FLUSH;
          else if (accept && s_last_i)  state <= IDLE;
        end
        FLUSH: begin
          if (flush_done_o)             state <= IDLE;
        end
        default:                        state <= IDLE;
      endcase
    end
  end

  // Saturating word and packet counters, stepped by FIFO writes.
  always_ff @(posedge clk_wr_i or negedge reset) begin
    if (!reset) begin
      word_cnt_o <= CNT_ZERO;
      pkt_cnt_o  <= CNT_ZERO;
    end else if (wr_o) begin
      if (word_cnt_o != CNT_MAX)
        word_cnt_o <= word_cnt_o + CNT_ONE;
      if (head_last && (pkt_cnt_o != CNT_MAX))
        pkt_cnt_o <= pkt_cnt_o + CNT_ONE;
    end
  end

  // Stall watchdog: down-counter reloaded whenever the buffer is not stuck
  // behind a full FIFO; reaching terminal count latches the sticky error.
  always_ff @(posedge clk_wr_i or negedge reset) begin
    if (!reset) begin
      stall_tmr   <= STALL_LOAD;
      stall_err_o <= 1'b0;
    end else if (!stalled) begin
      stall_tmr <= STALL_LOAD;
    end else if (stall_tmr != CNT_ZERO) begin
      stall_tmr <= stall_tmr - CNT_ONE;
      if (stall_tmr == CNT_ONE)
        stall_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl against a queue-based reference model.
module tb_fifo_wr_ctrl;

  localparam int DW   = 18;
  localparam int CW   = 4;
  localparam int SL   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_wr_i      = 1'b0;
  logic          reset         = 1'b0;
  logic          s_valid_i     = 1'b0;
  logic          s_last_i      = 1'b0;
  logic          flush_i       = 1'b0;
  logic          fifo_full_n_i = 1'b1;
  logic [DW-1:0] s_data_i      = '0;
  logic          s_ready_o;
  logic          wr_o;
  logic [DW-1:0] data_o;
  logic          busy_o;
  logic          flush_done_o;
  logic [CW-1:0] word_cnt_o;
  logic [CW-1:0] pkt_cnt_o;
  logic          stall_err_o;

  fifo_wr_ctrl #(
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .STALL_LIMIT (SL)
  ) dut (
    .clk_wr_i      (clk_wr_i),
    .reset         (reset),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .s_data_i      (s_data_i),
    .s_last_i      (s_last_i),
    .flush_i       (flush_i),
    .fifo_full_n_i (fifo_full_n_i),
    .wr_o          (wr_o),
    .data_o        (data_o),
    .busy_o        (busy_o),
    .flush_done_o  (flush_done_o),
    .word_cnt_o    (word_cnt_o),
    .pkt_cnt_o     (pkt_cnt_o),
    .stall_err_o   (stall_err_o)
  );

  always #5 clk_wr_i = ~clk_wr_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: buffered words as a queue of {last, data}.
  logic [DW:0] q[$];
  bit          m_flush;
  int          m_words;
  int          m_pkts;
  int          m_stall;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_flush = 0;
    m_words = 0;
    m_pkts  = 0;
    m_stall = 0;
    m_err   = 0;
  endtask

  task automatic check_all();
    bit e_wr;
    bit e_done;
    e_wr   = (q.size() != 0) && fifo_full_n_i;
    e_done = m_flush && ((q.size() - int'(e_wr)) == 0);
    chk("s_ready", s_ready_o, (q.size() < 2) && !m_flush);
    chk("wr", wr_o, e_wr);
    chk("busy", busy_o, (q.size() != 0) || m_flush);
    chk("flush_done", flush_done_o, e_done);
    chk("word_cnt", word_cnt_o, m_words);
    chk("pkt_cnt", pkt_cnt_o, m_pkts);
    chk("stall_err", stall_err_o, m_err);
    if (q.size() != 0) chk("data", data_o, q[0][DW-1:0]);
  endtask

  task automatic model_step();
    bit e_wr;
    bit e_acc;
    bit e_done;
    e_wr   = (q.size() != 0) && fifo_full_n_i;
    e_acc  = s_valid_i && (q.size() < 2) && !m_flush;
    e_done = m_flush && ((q.size() - int'(e_wr)) == 0);
    if ((q.size() != 0) && !fifo_full_n_i) begin
      m_stall++;
      if (m_stall >= SL) m_err = 1;
    end else begin
      m_stall = 0;
    end
    if (e_wr) begin
      if (m_words < CMAX) m_words++;
      if (q[0][DW] && (m_pkts < CMAX)) m_pkts++;
      void'(q.pop_front());
    end
    if (e_acc) q.push_back({s_last_i, s_data_i});
    if (m_flush) begin
      if (e_done) m_flush = 0;
    end else if (flush_i) begin
      m_flush = 1;
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input bit v, input bit l, input bit f, input bit fn);
    s_valid_i     = v;
    s_last_i      = l;
    s_data_i      = DW'($urandom);
    flush_i       = f;
    fifo_full_n_i = fn;
    @(negedge clk_wr_i);
    check_all();
    model_step();
    @(posedge clk_wr_i);
    #1;
  endtask

  // Asynchronous reset, applied away from the clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_ready", s_ready_o, 1);
    chk("rst_wr", wr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", flush_done_o, 0);
    chk("rst_words", word_cnt_o, 0);
    chk("rst_pkts", pkt_cnt_o, 0);
    chk("rst_err", stall_err_o, 0);
    @(posedge clk_wr_i);
    @(posedge clk_wr_i);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    @(posedge clk_wr_i);
    #1;
    do_reset();

    // 4-word packet, FIFO never full.
    for (int i = 0; i < 4; i++) step(1, i == 3, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("pkt4_words", word_cnt_o, 4);
    chk("pkt4_pkts", pkt_cnt_o, 1);

    // Streaming into a full FIFO for 10 cycles, then release.
    for (int i = 0; i < 10; i++) step(1, $urandom_range(0, 2) == 0, 0, 0);
    for (int i = 0; i < 6; i++)  step(1, $urandom_range(0, 2) == 0, 0, 1);
    for (int i = 0; i < 3; i++)  step(0, 0, 0, 1);

    // Watchdog: one buffered word stalled for exactly STALL_LIMIT cycles.
    do_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < SL - 1; i++) step(0, 0, 0, 0);
    chk("wd_before", stall_err_o, 0);
    step(0, 0, 0, 0);
    chk("wd_set", stall_err_o, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("wd_sticky", stall_err_o, 1);

    // Flush with 2 words buffered behind a full FIFO.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("flush_idle_busy", busy_o, 0);
    // Flush coinciding with an accept, then flush held high.
    step(1, 1, 1, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Counter saturation: 20 single-word packets.
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("sat_words", word_cnt_o, CMAX);
    chk("sat_pkts", pkt_cnt_o, CMAX);

    // Reset mid-packet with 2 words buffered: nothing written afterwards.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("pre_rst_busy", busy_o, 1);
    chk("pre_rst_ready", s_ready_o, 0);
    fifo_full_n_i = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
